// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - note FIFO that writes square-wave half-periods to the audio unit at note boundaries.
// Optional silence gap between notes is enabled with `define SEQ_GAP_EN.
module tone_sequencer #(
  parameter int DEPTH      = 8,
  parameter int TICK_DIV   = 50000,
  parameter int GAP_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              wdata,
  input  logic                     wenable,
  input  logic                     clear,
  output logic [31:0]              tone_wdata,
  output logic                     tone_wenable,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     busy,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
`ifdef SEQ_GAP_EN
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    STOP
`ifdef SEQ_GAP_EN
    , GAP
`endif
  } state_t;

  state_t state, state_nx;

  logic [31:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  count;
  logic           push, pop;
  logic [11:0]    head_dur;
  logic [19:0]    head_hp;

  logic [PW-1:0]  presc, presc_nx;
  logic [11:0]    remaining, rem_nx;
  logic [31:0]    tone_data_nx;
  logic           tone_we_nx;
  logic           tick, note_end;
`ifdef SEQ_GAP_EN
  logic [GW-1:0]  gap_cnt, gap_nx;
`endif

  assign level    = count;
  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign push     = wenable && !full && !clear;
  assign head_dur = mem[rd_ptr][31:20];
  assign head_hp  = mem[rd_ptr][19:0];

  assign tick     = (presc == PRESC_MAX);
  // remaining == 0 in PLAY only follows a discarded zero-duration entry: recheck the FIFO.
  assign note_end = (remaining == '0) || (tick && remaining == 12'd1);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
      if (wenable && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      presc        <= '0;
      remaining    <= '0;
      tone_wdata   <= '0;
      tone_wenable <= 1'b0;
`ifdef SEQ_GAP_EN
      gap_cnt      <= '0;
`endif
    end else begin
      state        <= state_nx;
      presc        <= presc_nx;
      remaining    <= rem_nx;
      tone_wdata   <= tone_data_nx;
      tone_wenable <= tone_we_nx;
`ifdef SEQ_GAP_EN
      gap_cnt      <= gap_nx;
`endif
    end
  end

  always_comb begin
    state_nx     = state;
    presc_nx     = presc;
    rem_nx       = remaining;
    tone_data_nx = tone_wdata;
    tone_we_nx   = 1'b0;
    pop          = 1'b0;
`ifdef SEQ_GAP_EN
    gap_nx       = gap_cnt;
`endif
    if (clear) begin
      state_nx = IDLE;
      presc_nx = '0;
      rem_nx   = '0;
      if (state == PLAY || state == STOP) begin
        tone_we_nx   = 1'b1;
        tone_data_nx = '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            pop = 1'b1;
            if (head_dur != '0) begin
              state_nx     = PLAY;
              rem_nx       = head_dur;
              presc_nx     = '0;
              tone_we_nx   = 1'b1;
              tone_data_nx = {12'b0, head_hp};
            end
          end
        end
        PLAY: begin
          if (tick) begin
            presc_nx = '0;
            rem_nx   = remaining - 12'd1;
          end else begin
            presc_nx = presc + PW'(1);
          end
          if (note_end) begin
            presc_nx = '0;
            rem_nx   = '0;
            if (empty) begin
              state_nx     = STOP;
              tone_we_nx   = 1'b1;
              tone_data_nx = '0;
            end else begin
`ifdef SEQ_GAP_EN
              state_nx     = GAP;
              gap_nx       = '0;
              tone_we_nx   = 1'b1;
              tone_data_nx = '0;
`else
              pop = 1'b1;
              if (head_dur != '0) begin
                rem_nx       = head_dur;
                tone_we_nx   = 1'b1;
                tone_data_nx = {12'b0, head_hp};
              end
`endif
            end
          end
        end
        // Silence strobe was registered on the way in; just return to IDLE.
        STOP: state_nx = IDLE;
`ifdef SEQ_GAP_EN
        GAP: begin
          if (gap_cnt == GAP_MAX) begin
            if (empty) begin
              state_nx = IDLE;
            end else begin
              pop = 1'b1;
              if (head_dur != '0) begin
                state_nx     = PLAY;
                rem_nx       = head_dur;
                presc_nx     = '0;
                tone_we_nx   = 1'b1;
                tone_data_nx = {12'b0, head_hp};
              end else begin
                state_nx = IDLE;
              end
            end
          end else begin
            gap_nx = gap_cnt + GW'(1);
          end
        end
`endif
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - directed bench for tone_sequencer (DEPTH=8, TICK_DIV=4, GAP_CYCLES=5).
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wdata;
  logic        wenable;
  logic        clear;
  logic [31:0] tone_wdata;
  logic        tone_wenable;
  logic [3:0]  level;
  logic        full, empty, busy, overflow;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int log_data[$];
  int log_cyc[$];

  always #5 clk = ~clk;

  tone_sequencer #(.DEPTH(8), .TICK_DIV(4), .GAP_CYCLES(5)) dut (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .wenable(wenable), .clear(clear),
    .tone_wdata(tone_wdata), .tone_wenable(tone_wenable), .level(level),
    .full(full), .empty(empty), .busy(busy), .overflow(overflow)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && tone_wenable === 1'b1) begin
      log_data.push_back(int'(tone_wdata));
      log_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [11:0] d, input logic [19:0] hp);
    wdata   = {d, hp};
    wenable = 1'b1;
    step(1);
    wenable = 1'b0;
  endtask

  task automatic wait_strobes(input string name, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (log_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout: got %0d strobes want %0d", name, log_data.size(), n);
    end
  endtask

  task automatic settle();
    bit idle_ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (busy === 1'b0 && empty === 1'b1) begin
        idle_ok = 1'b1;
        break;
      end
      step(1);
    end
    total++;
    if (!idle_ok) begin
      bad++;
      $display("FAIL settle: busy=%0b empty=%0b want 0/1", busy, empty);
    end
    step(2);
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wdata = '0; wenable = 1'b0; clear = 1'b0;
    step(3);
    total++; if (tone_wdata !== 32'd0) begin bad++; $display("FAIL rst_tone_wdata: got %0h want 0", tone_wdata); end
    total++; if (tone_wenable !== 1'b0) begin bad++; $display("FAIL rst_tone_wenable: got %0b want 0", tone_wenable); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %0b want 1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full: got %0b want 0", full); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %0b want 0", overflow); end
    rst_n = 1'b1;
    step(100);
    total++; if (log_data.size() != 0) begin bad++; $display("FAIL idle_strobes: got %0d want 0", log_data.size()); end
    total++; if (empty !== 1'b1 || busy !== 1'b0 || level !== 4'd0) begin
      bad++; $display("FAIL idle_flags: empty=%0b busy=%0b level=%0d want 1/0/0", empty, busy, level);
    end
  endtask

  task automatic test_two_notes();
    bit ok;
    settle();
    push(12'd3, 20'd100);
    step(1);
    push(12'd2, 20'd200);
    wait_strobes("two_notes", 3, 200, ok);
    if (ok) begin
      total++; if (log_data[0] != 100) begin bad++; $display("FAIL two_note1: got %0d want 100", log_data[0]); end
      total++; if (log_data[1] != 200) begin bad++; $display("FAIL two_note2: got %0d want 200", log_data[1]); end
      total++; if (log_data[2] != 0) begin bad++; $display("FAIL two_silence: got %0d want 0", log_data[2]); end
      total++; if (log_cyc[1] - log_cyc[0] != 12) begin bad++; $display("FAIL two_gap1: got %0d want 12", log_cyc[1] - log_cyc[0]); end
      total++; if (log_cyc[2] - log_cyc[1] != 8) begin bad++; $display("FAIL two_gap2: got %0d want 8", log_cyc[2] - log_cyc[1]); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL two_busy: got %0b want 0", busy); end
    end
    step(20);
    total++; if (log_data.size() != 3) begin bad++; $display("FAIL two_extra: got %0d strobes want 3", log_data.size()); end
  endtask

  task automatic test_overflow();
    settle();
    push(12'd100, 20'd500);
    step(3);
    for (int i = 0; i < 9; i++) begin
      wdata   = {12'd1, 20'(i + 1)};
      wenable = 1'b1;
      step(1);
      if (i == 7) begin
        total++; if (full !== 1'b1 || overflow !== 1'b0 || level !== 4'd8) begin
          bad++; $display("FAIL ovf_at8: full=%0b overflow=%0b level=%0d want 1/0/8", full, overflow, level);
        end
      end
    end
    wenable = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
    total++; if (level !== 4'd8) begin bad++; $display("FAIL ovf_level: got %0d want 8", level); end
    step(5);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_hold: got %0b want 1", overflow); end
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    total++; if (overflow !== 1'b0 || level !== 4'd0) begin
      bad++; $display("FAIL ovf_clear: overflow=%0b level=%0d want 0/0", overflow, level);
    end
    step(10);
  endtask

  task automatic test_zero_duration();
    bit ok;
    settle();
    push(12'd0, 20'd50);
    push(12'd1, 20'd60);
    wait_strobes("zero_dur", 2, 100, ok);
    if (ok) begin
      total++; if (log_data[0] != 60) begin bad++; $display("FAIL zero_first: got %0d want 60", log_data[0]); end
      total++; if (log_data[1] != 0) begin bad++; $display("FAIL zero_silence: got %0d want 0", log_data[1]); end
      total++; if (log_cyc[1] - log_cyc[0] != 4) begin bad++; $display("FAIL zero_gap: got %0d want 4", log_cyc[1] - log_cyc[0]); end
    end
    step(10);
    total++; if (log_data.size() != 2) begin bad++; $display("FAIL zero_extra: got %0d strobes want 2", log_data.size()); end
  endtask

  task automatic test_clear();
    int base;
    settle();
    push(12'd100, 20'd300);
    push(12'd5, 20'd1);
    push(12'd5, 20'd2);
    push(12'd5, 20'd3);
    step(3);
    total++; if (level !== 4'd3) begin bad++; $display("FAIL clr_queued: got %0d want 3", level); end
    base  = log_data.size();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    total++; if (tone_wenable !== 1'b1 || tone_wdata !== 32'd0) begin
      bad++; $display("FAIL clr_strobe: we=%0b data=%0d want 1/0", tone_wenable, tone_wdata);
    end
    total++; if (level !== 4'd0 || busy !== 1'b0 || full !== 1'b0) begin
      bad++; $display("FAIL clr_flags: level=%0d busy=%0b full=%0b want 0/0/0", level, busy, full);
    end
    step(30);
    total++; if (log_data.size() != base + 1) begin bad++; $display("FAIL clr_count: got %0d want %0d", log_data.size(), base + 1); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    settle();
    push(12'd1, 20'd70);
    push(12'd1, 20'd80);
`ifdef SEQ_GAP_EN
    wait_strobes("gap", 4, 200, ok);
    if (ok) begin
      total++; if (log_data[0] != 70 || log_data[1] != 0 || log_data[2] != 80 || log_data[3] != 0) begin
        bad++; $display("FAIL gap_data: got %0d %0d %0d %0d want 70 0 80 0", log_data[0], log_data[1], log_data[2], log_data[3]);
      end
      total++; if (log_cyc[1] - log_cyc[0] != 4) begin bad++; $display("FAIL gap_sil: got %0d want 4", log_cyc[1] - log_cyc[0]); end
      total++; if (log_cyc[2] - log_cyc[0] != 9) begin bad++; $display("FAIL gap_note2: got %0d want 9", log_cyc[2] - log_cyc[0]); end
      total++; if (log_cyc[3] - log_cyc[0] != 13) begin bad++; $display("FAIL gap_end: got %0d want 13", log_cyc[3] - log_cyc[0]); end
    end
`else
    wait_strobes("legato", 3, 200, ok);
    if (ok) begin
      total++; if (log_data[0] != 70 || log_data[1] != 80 || log_data[2] != 0) begin
        bad++; $display("FAIL legato_data: got %0d %0d %0d want 70 80 0", log_data[0], log_data[1], log_data[2]);
      end
      total++; if (log_cyc[1] - log_cyc[0] != 4) begin bad++; $display("FAIL legato_note2: got %0d want 4", log_cyc[1] - log_cyc[0]); end
      total++; if (log_cyc[2] - log_cyc[0] != 8) begin bad++; $display("FAIL legato_end: got %0d want 8", log_cyc[2] - log_cyc[0]); end
    end
`endif
    step(10);
  endtask

  initial begin
    test_reset();
    test_two_notes();
    test_overflow();
    test_zero_duration();
    test_clear();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
